// File: rtl/dlx_mem_initiator.sv
// Memory-stage master for the DLX ENABLE/READNOTWRITE/ADDRESS/INOUT_DATA bus.
// One load or store at a time: accept, drive the bus until DATA_READY or timeout, respond, then idle a cycle.
module dlx_mem_initiator #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_rnw_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_unsigned_i,
    input  logic [ADDRESS_SIZE-1:0] req_addr_i,
    input  logic [WORD_SIZE-1:0]    req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [WORD_SIZE-1:0]    rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic                    mem_enable_o,
    output logic                    mem_readnotwrite_o,
    output logic [ADDRESS_SIZE-1:0] mem_address_o,
    inout  wire logic [WORD_SIZE-1:0] mem_data_io,
    input  logic                    mem_data_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_GAP} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    rnw_q, rnw_d;
    logic                    uns_q, uns_d;
    logic [1:0]              code_q, code_d;
    logic [ADDRESS_SIZE-3:0] waddr_q, waddr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [WORD_SIZE-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_error_q, rsp_error_d;
    logic                    mem_enable_q, mem_enable_d;
    logic                    mem_rnw_q, mem_rnw_d;
    logic [ADDRESS_SIZE-1:0] mem_address_q, mem_address_d;
    logic                    addr_lsb_unused;

    // Byte-lane position is encoded in the size code, so the request's byte offset is dropped.
    assign addr_lsb_unused = ^req_addr_i[1:0];

    function automatic logic [1:0] size_code(input logic [1:0] size);
        return (size == 2'b01 || size == 2'b10) ? size : 2'b00;
    endfunction

    function automatic logic [WORD_SIZE-1:0] mask_store(input logic [1:0] code, input logic [WORD_SIZE-1:0] d);
        case (code)
            2'b01:   return {{(WORD_SIZE-8){1'b0}}, d[7:0]};
            2'b10:   return {{(WORD_SIZE-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [WORD_SIZE-1:0] extend_load(input logic [1:0] code, input logic uns,
                                                         input logic [WORD_SIZE-1:0] d);
        case (code)
            2'b01:   return {{(WORD_SIZE-8){~uns & d[7]}}, d[7:0]};
            2'b10:   return {{(WORD_SIZE-16){~uns & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rnw_d         = rnw_q;
        uns_d         = uns_q;
        code_d        = code_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        rsp_rdata_d   = '0;
        rsp_error_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    rnw_d   = req_rnw_i;
                    uns_d   = req_unsigned_i;
                    code_d  = size_code(req_size_i);
                    waddr_d = req_addr_i[ADDRESS_SIZE-1:2];
                    wdata_d = mask_store(size_code(req_size_i), req_wdata_i);
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Ready on the final count still completes the access normally.
                if (mem_data_ready_i) begin
                    state_d = S_RESP;
                    if (rnw_q) rsp_rdata_d = extend_load(code_q, uns_q, mem_data_io);
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    rsp_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        req_ready_d   = (state_d == S_IDLE);
        rsp_valid_d   = (state_d == S_RESP);
        mem_enable_d  = (state_d == S_ACCESS);
        mem_rnw_d     = (state_d == S_ACCESS) ? rnw_d : 1'b1;
        mem_address_d = (state_d == S_ACCESS) ? {waddr_d, code_d} : mem_address_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rnw_q         <= 1'b1;
            uns_q         <= 1'b0;
            code_q        <= 2'b00;
            waddr_q       <= '0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_rnw_q     <= 1'b1;
            mem_address_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rnw_q         <= rnw_d;
            uns_q         <= uns_d;
            code_q        <= code_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            mem_enable_q  <= mem_enable_d;
            mem_rnw_q     <= mem_rnw_d;
            mem_address_q <= mem_address_d;
        end
    end

    // The bus is driven only while a store is in ACCESS; the responder drives it only for loads.
    assign mem_data_io = (state_q == S_ACCESS && !rnw_q) ? wdata_q : {WORD_SIZE{1'bz}};

    assign req_ready_o        = req_ready_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_rdata_o        = rsp_rdata_q;
    assign rsp_error_o        = rsp_error_q;
    assign mem_enable_o       = mem_enable_q;
    assign mem_readnotwrite_o = mem_rnw_q;
    assign mem_address_o      = mem_address_q;

endmodule

// File: tb/tb_dlx_mem_initiator.sv
// Directed plus randomized bench for dlx_mem_initiator with a latency-programmable responder.
module tb_dlx_mem_initiator;
    localparam int W = 32;
    localparam int A = 16;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0, req_rnw = 1'b1, req_unsigned = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [A-1:0]  req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    wire           req_ready, rsp_valid, rsp_error, mem_enable, mem_rnw, mem_ready;
    wire  [W-1:0]  rsp_rdata;
    wire  [A-1:0]  mem_address;
    wire  [W-1:0]  mem_data;

    // Responder: raises DATA_READY once ENABLE has been high resp_lat cycles (0 = never).
    int            resp_lat = 1;
    logic [W-1:0]  resp_word = '0;
    logic          ready_noise = 1'b0;
    int            en_cycles = 0;
    int            cyc = 0;
    always @(posedge clk) en_cycles <= mem_enable ? en_cycles + 1 : 0;
    always @(posedge clk) cyc <= cyc + 1;
    wire resp_ready = mem_enable && (resp_lat != 0) && (en_cycles + 1 >= resp_lat);
    wire tb_drive   = resp_ready && mem_rnw;
    assign mem_ready = resp_ready || ready_noise;
    assign mem_data  = tb_drive ? resp_word : {W{1'bz}};

    dlx_mem_initiator #(.WORD_SIZE(W), .ADDRESS_SIZE(A), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error), .mem_enable_o(mem_enable), .mem_readnotwrite_o(mem_rnw),
        .mem_address_o(mem_address), .mem_data_io(mem_data), .mem_data_ready_i(mem_ready)
    );

    int n_pass = 0;
    int n_total = 0;
    int accept_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: plain arithmetic on the access rules.
    function automatic logic [31:0] model_addr(input logic [15:0] addr, input logic [1:0] size);
        logic [31:0] base;
        base = (32'(addr) / 4) * 4;
        return base + ((size == 2'd1) ? 32'd1 : (size == 2'd2) ? 32'd2 : 32'd0);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd1) return d % 256;
        if (size == 2'd2) return d % 65536;
        return d;
    endfunction

    function automatic logic [31:0] model_rdata(input logic rnw, input logic [1:0] size, input logic uns,
                                                input logic [31:0] word, input bit timeout);
        logic [31:0] v;
        if (timeout || !rnw) return 32'd0;
        if (size == 2'd1) begin
            v = word % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (size == 2'd2) begin
            v = word % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return word;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        check({tag, "_mem_enable"}, 32'(mem_enable), 32'd0);
        check({tag, "_mem_rnw"}, 32'(mem_rnw), 32'd1);
        check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        check({tag, "_mem_data_z"}, mem_data, {W{1'bz}});
    endtask

    task automatic access(input logic rnw, input logic [1:0] size, input logic uns, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int lat, input bit hold);
        bit timeout;
        int exp_en, en_seen, guard;
        bit got;
        logic [31:0] e_addr, e_wdata, e_rdata;
        timeout = (lat == 0) || (lat > T);
        exp_en  = timeout ? T : lat;
        e_addr  = model_addr(addr, size);
        e_wdata = model_wdata(size, wdata);
        e_rdata = model_rdata(rnw, size, uns, word, timeout);
        @(negedge clk);
        resp_lat = lat; resp_word = word;
        req_rnw = rnw; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        @(negedge clk);
        accept_cyc = cyc;
        if (!hold) req_valid = 1'b0;
        req_addr = 16'($urandom); req_wdata = $urandom; req_size = 2'($urandom);
        req_rnw = 1'($urandom); req_unsigned = 1'($urandom);
        en_seen = 0; got = 1'b0; guard = 0;
        while (!got && guard < T + 10) begin
            if (mem_enable) begin
                en_seen++;
                check("mem_address", 32'(mem_address), e_addr);
                check("mem_rnw", 32'(mem_rnw), 32'(rnw));
                if (!rnw) check("store_data", mem_data, e_wdata);
            end else if (rsp_valid) begin
                got = 1'b1;
                check("rsp_rdata", rsp_rdata, e_rdata);
                check("rsp_error", 32'(rsp_error), 32'(timeout));
                check("resp_req_ready", 32'(req_ready), 32'd0);
            end
            if (!tb_drive && !(mem_enable && !mem_rnw)) check("bus_z", mem_data, {W{1'bz}});
            if (!got) begin
                @(negedge clk);
                guard++;
            end
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("enable_cycles", 32'(en_seen), 32'(exp_en));
        @(negedge clk);
        check("gap_rsp_valid", 32'(rsp_valid), 32'd0);
        check("gap_enable", 32'(mem_enable), 32'd0);
        check("gap_req_ready", 32'(req_ready), 32'd0);
        check("gap_bus_z", mem_data, {W{1'bz}});
        $display("access rnw=%0d size=%0d uns=%0d addr=%h lat=%0d -> accepted cyc %0d", rnw, size, uns, addr, lat, accept_cyc);
    endtask

    initial begin
        int c0, c1, c2;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        access(1'b1, 2'b00, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
        access(1'b1, 2'b01, 1'b0, 16'h0043, 32'h0, 32'h0000_0080, 1, 1'b0);
        access(1'b1, 2'b01, 1'b1, 16'h0043, 32'h0, 32'h0000_0080, 3, 1'b0);
        access(1'b1, 2'b10, 1'b0, 16'h0102, 32'h0, 32'h1234_9ABC, 2, 1'b0);
        access(1'b0, 2'b10, 1'b0, 16'h0020, 32'h1234_ABCD, 32'h0, 2, 1'b0);
        access(1'b0, 2'b01, 1'b0, 16'h0031, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
        access(1'b1, 2'b00, 1'b0, 16'h0200, 32'h0, 32'h5555_AAAA, 0, 1'b0);
        access(1'b1, 2'b11, 1'b0, 16'h0204, 32'h0, 32'h8765_4321, 1, 1'b0);
        access(1'b1, 2'b10, 1'b1, 16'h0300, 32'h0, 32'hFFFF_8001, T, 1'b0);
        access(1'b0, 2'b00, 1'b0, 16'h0304, 32'h0BAD_C0DE, 32'h0, T + 1, 1'b0);

        access(1'b1, 2'b00, 1'b0, 16'h0400, 32'h0, 32'h1111_1111, 1, 1'b1);
        c0 = accept_cyc;
        access(1'b0, 2'b00, 1'b0, 16'h0404, 32'h2222_2222, 32'h0, 1, 1'b1);
        c1 = accept_cyc;
        access(1'b1, 2'b01, 1'b0, 16'h0408, 32'h0, 32'h0000_00F0, 1, 1'b0);
        c2 = accept_cyc;
        check("b2b_spacing_1", 32'(c1 - c0), 32'd4);
        check("b2b_spacing_2", 32'(c2 - c1), 32'd4);

        @(negedge clk);
        ready_noise = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("noise_rsp_valid", 32'(rsp_valid), 32'd0);
            check("noise_enable", 32'(mem_enable), 32'd0);
        end
        ready_noise = 1'b0;

        for (int i = 0; i < 30; i++) begin
            int lat;
            lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, T + 2)) : int'($urandom_range(1, 4));
            access(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), $urandom, $urandom, lat, 1'b0);
        end

        @(negedge clk);
        resp_lat = 0;
        req_rnw = 1'b1; req_size = 2'b00; req_addr = 16'h0500; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_enable", 32'(mem_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        repeat (2) begin
            @(negedge clk);
            check("in_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        access(1'b1, 2'b00, 1'b0, 16'h0010, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
